// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dds_pkg
// Brief    : Shared types, quadrant-decode constants and quarter-wave ROM
//            entry generator for the multi-channel DDS sine generator.
// Revision : 1.0 - initial release
// ============================================================================
package dds_pkg;

  // Widths the shared structs are built with; the top-level defaults track these.
  localparam int DDS_ACC_SIZE      = 24;
  localparam int DDS_CH_SIZE       = 2;
  localparam int DDS_LUT_ADDR_SIZE = 8;

  localparam real DDS_PI = 3.14159265358979323846;

  // Quadrant decode: bit 0 of the quadrant mirrors the ROM address,
  // bit 1 selects the negative half of the period.
  localparam int QUAD_MIRROR_BIT = 0;
  localparam int QUAD_NEG_BIT    = 1;

  // Runtime-programmable per-channel configuration.
  typedef struct packed {
    logic [DDS_ACC_SIZE-1:0] step;
    logic [DDS_ACC_SIZE-1:0] phase;
  } ch_cfg_t;

  // Issue stage: top bits of the summed phase for the issued channel.
  typedef struct packed {
    logic                         valid;
    logic [DDS_CH_SIZE-1:0]       ch;
    logic [DDS_LUT_ADDR_SIZE+1:0] pbits;
  } issue_stage_t;

  // Fold stage: quarter-wave ROM address plus sign of the result.
  typedef struct packed {
    logic                         valid;
    logic [DDS_CH_SIZE-1:0]       ch;
    logic [DDS_LUT_ADDR_SIZE-1:0] addr;
    logic                         neg;
  } fold_stage_t;

  // ROM stage: sideband travelling alongside the registered ROM read.
  typedef struct packed {
    logic                   valid;
    logic [DDS_CH_SIZE-1:0] ch;
    logic                   neg;
  } rom_stage_t;

  // Entry j = round(A * sin(pi/2 * (j + 0.5) / 2^L)), A = 2^(S-1) - 1.
  // Evaluated only with constant arguments while the ROM is elaborated.
  function automatic int rom_entry(input int j, input int sine_size, input int lut_addr_size);
    real amp;
    real x;
    amp = real'((1 << (sine_size - 1)) - 1);
    x   = amp * $sin(DDS_PI / 2.0 * (real'(j) + 0.5) / real'(1 << lut_addr_size));
    return $rtoi(x + 0.5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/quarter_sine_rom.sv
`default_nettype none
// ============================================================================
// Module   : quarter_sine_rom
// Brief    : Quarter-wave sine ROM with a one-cycle registered read; contents
//            are generated at elaboration from dds_pkg::rom_entry.
// Revision : 1.0 - initial release
// ============================================================================
module quarter_sine_rom
  import dds_pkg::*;
#(
  parameter int SINE_SIZE     = 12,
  parameter int LUT_ADDR_SIZE = 8
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic [LUT_ADDR_SIZE-1:0] addr_i,
  output logic [SINE_SIZE-1:0]     data_o
);

  localparam int DEPTH = 1 << LUT_ADDR_SIZE;

  logic [SINE_SIZE-1:0] rom_table [DEPTH];
  logic [SINE_SIZE-1:0] data_q;

  for (genvar j = 0; j < DEPTH; j++) begin : g_rom
    localparam int ENTRY = rom_entry(j, SINE_SIZE, LUT_ADDR_SIZE);
    assign rom_table[j] = ENTRY[SINE_SIZE-1:0];
  end

  // Registered read; holds its value while the pipeline is stalled.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      data_q <= rom_table[addr_i];
    end
  end

  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/dds_sine_multi.sv
`default_nettype none
// ============================================================================
// Module   : dds_sine_multi
// Brief    : Time-multiplexed multi-channel DDS sine generator. Round-robin
//            issue of per-channel phase accumulators into a 4-stage
//            issue/fold/ROM/output pipeline with valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module dds_sine_multi
  import dds_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CH_SIZE       = DDS_CH_SIZE,
  parameter int SINE_SIZE     = 12,
  parameter int ACC_SIZE      = DDS_ACC_SIZE,
  parameter int LUT_ADDR_SIZE = DDS_LUT_ADDR_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CH_SIZE-1:0]   cfg_ch_i,
  input  logic [ACC_SIZE-1:0]  cfg_step_i,
  input  logic [ACC_SIZE-1:0]  cfg_phase_i,
  input  logic                 cfg_restart_i,
  output logic                 cfg_err_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CH_SIZE-1:0]   out_ch_o,
  output logic [SINE_SIZE-1:0] out_sample_o
);

  logic [ACC_SIZE-1:0]      acc_q [NUM_CH];
  ch_cfg_t                  cfg_q [NUM_CH];
  logic [CH_SIZE-1:0]       ch_ptr_q, ch_ptr_d;
  issue_stage_t             s1_q;
  fold_stage_t              s2_q;
  rom_stage_t               s3_q;
  logic                     out_valid_q;
  logic [CH_SIZE-1:0]       out_ch_q;
  logic [SINE_SIZE-1:0]     out_sample_q;
  logic                     cfg_err_q;

  logic                     stall;
  logic                     issue;
  logic                     cfg_hit;
  logic [ACC_SIZE-1:0]      phase_p;
  logic [1:0]               quad;
  logic [LUT_ADDR_SIZE-1:0] quad_k;
  logic [LUT_ADDR_SIZE-1:0] fold_addr;
  logic                     fold_neg;
  logic [SINE_SIZE-1:0]     rom_data;

  // A held output sample freezes every stage, so nothing is lost or duplicated.
  assign stall   = out_valid_q & ~out_ready_i;
  assign issue   = enable_i & ~stall;
  assign cfg_hit = cfg_valid_i & (int'(cfg_ch_i) < NUM_CH);

  assign phase_p  = acc_q[ch_ptr_q] + cfg_q[ch_ptr_q].phase;
  assign ch_ptr_d = (int'(ch_ptr_q) == NUM_CH - 1) ? '0 : ch_ptr_q + 1'b1;

  // Mirror the address in odd quadrants, negate in the second half-period.
  assign quad      = s1_q.pbits[LUT_ADDR_SIZE+1:LUT_ADDR_SIZE];
  assign quad_k    = s1_q.pbits[LUT_ADDR_SIZE-1:0];
  assign fold_addr = quad[QUAD_MIRROR_BIT] ? ~quad_k : quad_k;
  assign fold_neg  = quad[QUAD_NEG_BIT];

  quarter_sine_rom #(
    .SINE_SIZE     (SINE_SIZE),
    .LUT_ADDR_SIZE (LUT_ADDR_SIZE)
  ) u_rom (
    .clk_i  (clk_i),
    .en_i   (~stall),
    .addr_i (s2_q.addr),
    .data_o (rom_data)
  );

  // Per-channel accumulator and config; a restart write overrides the issue update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cfg_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (issue && int'(ch_ptr_q) == c) begin
          acc_q[c] <= acc_q[c] + cfg_q[c].step;
        end
        if (cfg_hit && int'(cfg_ch_i) == c) begin
          cfg_q[c].step  <= cfg_step_i;
          cfg_q[c].phase <= cfg_phase_i;
          if (cfg_restart_i) begin
            acc_q[c] <= '0;
          end
        end
      end
    end
  end

  // Round-robin channel pointer, advancing only on an actual issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ch_ptr_q <= '0;
    end else if (issue) begin
      ch_ptr_q <= ch_ptr_d;
    end
  end

  // Issue -> fold -> ROM -> output pipeline; every stage holds during a stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_sample_q <= '0;
    end else if (!stall) begin
      s1_q        <= '{valid: issue, ch: ch_ptr_q,
                       pbits: phase_p[ACC_SIZE-1 -: LUT_ADDR_SIZE+2]};
      s2_q        <= '{valid: s1_q.valid, ch: s1_q.ch, addr: fold_addr, neg: fold_neg};
      s3_q        <= '{valid: s2_q.valid, ch: s2_q.ch, neg: s2_q.neg};
      out_valid_q <= s3_q.valid;
      if (s3_q.valid) begin
        out_ch_q     <= s3_q.ch;
        out_sample_q <= s3_q.neg ? -rom_data : rom_data;
      end
    end
  end

  // Out-of-range write target is flagged for exactly one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_valid_i & ~cfg_hit;
    end
  end

  assign cfg_ready_o  = 1'b1;
  assign cfg_err_o    = cfg_err_q;
  assign out_valid_o  = out_valid_q;
  assign out_ch_o     = out_ch_q;
  assign out_sample_o = out_sample_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_sine_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_sine_multi
// Brief    : Self-checking bench for dds_sine_multi with a behavioural model
//            of the channel accumulators, sine shape and output timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_sine_multi;

  localparam int NUM_CH    = 3;
  localparam int CH_SIZE   = 2;
  localparam int SINE_SIZE = 12;
  localparam int ACC_SIZE  = 24;
  localparam int LUT       = 8;
  localparam int unsigned ACC_MASK = 32'h00FF_FFFF;
  localparam real PI = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enable;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_SIZE-1:0]   cfg_ch;
  logic [ACC_SIZE-1:0]  cfg_step;
  logic [ACC_SIZE-1:0]  cfg_phase;
  logic                 cfg_restart;
  logic                 cfg_err;
  logic                 out_valid;
  logic                 out_ready;
  logic [CH_SIZE-1:0]   out_ch;
  logic [SINE_SIZE-1:0] out_sample;

  always #5 clk = ~clk;

  dds_sine_multi #(
    .NUM_CH        (NUM_CH),
    .CH_SIZE       (CH_SIZE),
    .SINE_SIZE     (SINE_SIZE),
    .ACC_SIZE      (ACC_SIZE),
    .LUT_ADDR_SIZE (LUT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .cfg_valid_i   (cfg_valid),
    .cfg_ready_o   (cfg_ready),
    .cfg_ch_i      (cfg_ch),
    .cfg_step_i    (cfg_step),
    .cfg_phase_i   (cfg_phase),
    .cfg_restart_i (cfg_restart),
    .cfg_err_o     (cfg_err),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_ch_o      (out_ch),
    .out_sample_o  (out_sample)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int unsigned m_acc   [NUM_CH];
  int unsigned m_step  [NUM_CH];
  int unsigned m_phase [NUM_CH];
  int          m_ptr;
  bit          m_v [4];
  int          m_c [4];
  int          m_s [4];
  bit          m_ov;
  int          m_och;
  int          m_os;
  bit          m_err;

  // Ideal sine of the phase bin containing p, rounded half away from zero.
  function automatic int sine_of(input int unsigned p);
    int unsigned m;
    real x;
    m = p >> (ACC_SIZE - LUT - 2);
    x = (2.0 ** (SINE_SIZE - 1) - 1.0) *
        $sin(2.0 * PI * (real'(m) + 0.5) / real'(1 << (LUT + 2)));
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_acc[c] = 0; m_step[c] = 0; m_phase[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0; m_c[i] = 0; m_s[i] = 0;
    end
    m_ptr = 0; m_ov = 1'b0; m_och = 0; m_os = 0; m_err = 1'b0;
  endtask

  // One clock edge: a sample issued at edge N becomes visible after edge N+3;
  // a held output freezes all in-flight samples.
  task automatic model_edge();
    bit          stalled;
    int unsigned p;
    if (!rst_n) return;
    stalled = m_ov && !out_ready;
    m_err   = cfg_valid && (int'(cfg_ch) >= NUM_CH);
    if (!stalled) begin
      m_ov = m_v[3];
      if (m_v[3]) begin
        m_och = m_c[3];
        m_os  = m_s[3];
      end
      for (int i = 3; i > 1; i--) begin
        m_v[i] = m_v[i-1]; m_c[i] = m_c[i-1]; m_s[i] = m_s[i-1];
      end
      m_v[1] = 1'b0;
      if (enable) begin
        p          = (m_acc[m_ptr] + m_phase[m_ptr]) & ACC_MASK;
        m_v[1]     = 1'b1;
        m_c[1]     = m_ptr;
        m_s[1]     = sine_of(p);
        m_acc[m_ptr] = (m_acc[m_ptr] + m_step[m_ptr]) & ACC_MASK;
        m_ptr      = (m_ptr + 1) % NUM_CH;
      end
    end
    if (cfg_valid && int'(cfg_ch) < NUM_CH) begin
      m_step[cfg_ch]  = cfg_step;
      m_phase[cfg_ch] = cfg_phase;
      if (cfg_restart) m_acc[cfg_ch] = 0;
    end
  endtask

  // Transferred samples per channel, as observed on the DUT.
  int q0[$];
  int q1[$];
  int q2[$];

  task automatic tick();
    if (out_valid && out_ready) begin
      case (int'(out_ch))
        0:       q0.push_back(int'($signed(out_sample)));
        1:       q1.push_back(int'($signed(out_sample)));
        default: q2.push_back(int'($signed(out_sample)));
      endcase
    end
    @(posedge clk);
    model_edge();
    #1;
    check_eq("out_valid", int'(out_valid), int'(m_ov));
    check_eq("cfg_err", int'(cfg_err), int'(m_err));
    if (m_ov) begin
      check_eq("out_ch", int'(out_ch), m_och);
      check_eq("out_sample", int'($signed(out_sample)), m_os);
    end
  endtask

  task automatic cfg_write(input int ch, input int unsigned step, input int unsigned phase,
                           input bit restart);
    cfg_valid   = 1'b1;
    cfg_ch      = CH_SIZE'(ch);
    cfg_step    = ACC_SIZE'(step);
    cfg_phase   = ACC_SIZE'(phase);
    cfg_restart = restart;
    tick();
    cfg_valid   = 1'b0;
    cfg_restart = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int exp0 [4];
    int exp1 [4];
    int exp2 [2];
    int first_edge;
    int first_ch;
    int first_smp;
    int waited;
    exp0 = '{6, 2047, -6, -2047};
    exp1 = '{2047, -6, -2047, 6};
    exp2 = '{6, -6};

    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_step = '0; cfg_phase = '0; cfg_restart = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (3) tick();
    check_eq("rst_cfg_ready", int'(cfg_ready), 1);
    check_eq("rst_out_sample", int'(out_sample), 0);
    check_eq("rst_out_ch", int'(out_ch), 0);
    rst_n = 1'b1;

    // Quarter-step, 90-degree offset and descending-wrap channels.
    cfg_write(0, 32'h0040_0000, 0, 1'b1);
    cfg_write(1, 32'h0040_0000, 32'h0040_0000, 1'b1);
    cfg_write(2, 32'h00FF_FFFF, 0, 1'b1);
    q0.delete(); q1.delete(); q2.delete();
    enable = 1'b1;
    repeat (24) tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("quarter_ch0", (q0.size() > i) ? q0[i] : 99999, exp0[i]);
      check_eq("offset_ch1", (q1.size() > i) ? q1[i] : 99999, exp1[i]);
    end
    for (int i = 0; i < 2; i++)
      check_eq("wrap_ch2", (q2.size() > i) ? q2[i] : 99999, exp2[i]);

    // Backpressure mid-stream: sequence must continue without loss or repeats.
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    repeat (12) tick();
    check_eq("bp_ch0_len", int'(q0.size() >= 10), 1);
    for (int i = 0; i < q0.size(); i++) check_eq("bp_ch0_seq", q0[i], exp0[i % 4]);
    for (int i = 0; i < q1.size(); i++) check_eq("bp_ch1_seq", q1[i], exp1[i % 4]);

    // Restart write colliding with the issue of the same channel.
    waited = 0;
    while (m_ptr != 0 && waited < NUM_CH) begin
      tick();
      waited++;
    end
    check_eq("collide_align", m_ptr, 0);
    cfg_write(0, 32'h0040_0000, 0, 1'b1);
    tick();
    q0.delete();
    repeat (12) tick();
    check_eq("collide_next", (q0.size() > 1) ? q0[1] : 99999, 6);
    check_eq("collide_after", (q0.size() > 2) ? q0[2] : 99999, 2047);

    // Out-of-range write target.
    cfg_write(NUM_CH, 32'h0012_3456, 32'h0065_4321, 1'b1);
    check_eq("cfg_err_pulse", int'(cfg_err), 1);
    tick();
    check_eq("cfg_err_clear", int'(cfg_err), 0);

    // Randomized traffic with config writes, stalls and enable gaps.
    repeat (400) begin
      enable      = ($urandom_range(0, 4) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      cfg_valid   = ($urandom_range(0, 7) == 0);
      cfg_ch      = CH_SIZE'($urandom_range(0, 3));
      cfg_step    = ACC_SIZE'($urandom);
      cfg_phase   = ACC_SIZE'($urandom);
      cfg_restart = $urandom_range(0, 1) == 1;
      tick();
    end
    cfg_valid = 1'b0; cfg_restart = 1'b0; enable = 1'b1; out_ready = 1'b1;
    repeat (6) tick();

    // Asynchronous reset mid-stream.
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_valid", int'(out_valid), 0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    first_edge = -1; first_ch = -1; first_smp = 99999;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (first_edge < 0 && out_valid) begin
        first_edge = e;
        first_ch   = int'(out_ch);
        first_smp  = int'($signed(out_sample));
      end
    end
    check_eq("rst_latency", first_edge, 4);
    check_eq("rst_first_ch", first_ch, 0);
    check_eq("rst_first_sample", first_smp, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_sine_multi.md
# dds_sine_multi

Multi-channel, time-multiplexed direct digital synthesis (DDS) sine generator that replaces table-walk sine generation with per-channel phase accumulators and a quarter-wave lookup ROM. Each channel has its own runtime-programmable frequency step and phase offset. The block emits one signed sample per cycle, round-robin across channels, on a valid/ready stream. It feeds the modulation/mixer stages and any sink that needs several phase-related tones from one clock.

## Interface
- NUM_CH, 4: number of channels, 1..16.
- CH_SIZE, 2: channel index width, equal to max(1, clog2(NUM_CH)).
- SINE_SIZE, 12: output sample width, two's complement.
- ACC_SIZE, 24: phase accumulator width; one full sine period is 2^ACC_SIZE.
- LUT_ADDR_SIZE, 8: quarter-wave ROM address width; the ROM has 2^LUT_ADDR_SIZE entries.

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  allows new channel issues into the pipeline.
- cfg_valid  in  1  configuration write strobe.
- cfg_ready  out  1  tied to 1 (writes always accepted).
- cfg_ch  in  CH_SIZE  channel targeted by the write.
- cfg_step  in  ACC_SIZE  frequency step, unsigned.
- cfg_phase  in  ACC_SIZE  phase offset, unsigned, modulo 2^ACC_SIZE.
- cfg_restart  in  1  with a write, also clears that channel's accumulator.
- cfg_err  out  1  one-cycle pulse when a write targets cfg_ch >= NUM_CH.
- out_valid  out  1  out_sample is valid.
- out_ready  in  1  sink accepts the sample.
- out_ch  out  CH_SIZE  channel that produced out_sample.
- out_sample  out  SINE_SIZE  signed sine sample.

## Operation
- Per-channel state: acc, step, phase, each ACC_SIZE wide. All reset to 0.
- Channel pointer ch_ptr:
  - It resets to 0.
  - It advances 0..NUM_CH-1 and wraps to 0 on every issue.
- Issue conditions: enable=1 and the pipeline is not stalled.
- On issue of channel c:
  - Form p = acc[c] + phase[c], modulo 2^ACC_SIZE.
  - Update acc[c] <= acc[c] + step[c], modulo 2^ACC_SIZE.
  - Send p's top LUT_ADDR_SIZE+2 bits and c down the pipeline.
- Fold stage:
  - q = top 2 bits of p; k = next LUT_ADDR_SIZE bits.
  - Address is k for q=0 or q=2, and ~k for q=1 or q=3.
  - Negate flag = q[1].
- ROM stage: registered read of the quarter-wave ROM.
  - Entry j = round((2^(SINE_SIZE-1)-1) * sin(pi/2 * (j+0.5) / 2^LUT_ADDR_SIZE)).
  - The half-sample offset makes the folded wave symmetric, so no endpoint special case is needed.
- Output stage:
  - out_sample = negate ? -rom : rom.
  - The range is ±(2^(SINE_SIZE-1)-1), so -2^(SINE_SIZE-1) never appears.
- Configuration write (cfg_valid=1, cfg_ch < NUM_CH):
  - step and phase of the target channel are updated at the clock edge.
  - cfg_restart=1 also sets acc to 0.
- Write to the channel issuing in the same cycle:
  - That issue uses the old step, phase and acc.
  - The new values take effect from that channel's next issue.
  - When restart collides with issue, the restart wins: acc <= 0, not acc+step.
- Out-of-range cfg_ch: no state change; cfg_err pulses 1 in the next cycle.
- enable=0: no new issues; in-flight samples drain normally; ch_ptr holds its value.

## Timing
- Latency: issue at edge N gives out_valid=1 after edge N+3.
- Throughput: one sample per cycle while out_ready=1 and enable=1.
- Backpressure:
  - When out_valid=1 and out_ready=0, the whole pipeline stalls.
  - During a stall: no issue, no acc update, and out_sample and out_ch hold stable.
- Transfer happens when out_valid and out_ready are both 1.
- out_valid falls only after a transfer with no new sample behind it.
- Reset values: out_valid=0, out_sample=0, out_ch=0, cfg_err=0, every pipeline valid bit=0.
- Reset mid-operation: in-flight samples are discarded immediately and nothing is emitted until 3 edges after the first issue following reset release.
- cfg writes are accepted during a stall and during enable=0.

## Structure
- Package dds_pkg holds:
  - the channel configuration struct (step, phase);
  - the pipeline-stage structs (valid, ch, addr, neg);
  - the quadrant decode constants;
  - a ROM-entry helper function that computes each entry at elaboration.
- Sub-module quarter_sine_rom:
  - parameters SINE_SIZE and LUT_ADDR_SIZE;
  - ports clock, en, addr, data;
  - one-cycle registered read, contents generated from the dds_pkg helper.

## Test plan
- Quarter-step sequence. Setup: NUM_CH=1, SINE_SIZE=12, ACC_SIZE=24, LUT_ADDR_SIZE=8, step=2^22, phase=0, sink always ready. Required samples: 6, 2047, -6, -2047, repeating.
- Phase offset. Two channels, both with step=2^22; channel 1 phase=2^22 (90°). Required: channel 1 samples lead channel 0 by one quarter. Channel 0 gives 6, 2047, …; channel 1 gives 2047, -6, …; out_ch alternates 0, 1.
- Backpressure. Hold out_ready=0 for 5 cycles mid-stream. Required: out_sample and out_ch are stable, no samples are lost or duplicated, and after release the sequence continues exactly.
- Restart collision. Issue cfg_restart to the channel issuing in that cycle. Required: its next sample comes from p=phase, i.e. 6 for phase=0. Also, a write with cfg_ch=NUM_CH gives cfg_err=1 for one cycle and no state change.
- Wrap. step=2^24-1 (−1 modulo 2^24), phase=0. Required: the accumulator wraps to 2^24-1, and samples follow the descending phase sequence without glitches.
- Async reset. Assert reset_n=0 mid-stream. Required: out_valid=0 immediately. After release with enable=1, the first out_valid is on the 3rd edge after the first issue, with the channel 0 sample from acc=0.
